execute_writeback: RTL and testbench

EXECUTE_WRITEBACK -- requirements
Module: execute_writeback

---
 rtl/execute_writeback_if.sv | 47 ++++
 rtl/execute_writeback.sv | 157 +++++++++++++++
 tb/tb_execute_writeback.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/execute_writeback_if.sv
// Execute/writeback bundle: issue lanes in, result broadcast (CDB) and
// address-generation FIFO handshake out.
interface execute_writeback_if #(
  parameter int ISSUE_PORTS   = 3,
  parameter int REG_SIZE      = 32,
  parameter int NUM_TAGS      = 64,
  parameter int ROB_SIZE      = 64,
  parameter int NUM_TAGS_LOG2 = $clog2(NUM_TAGS),
  parameter int ROB_SIZE_LOG2 = $clog2(ROB_SIZE)
);
  // issue side
  logic [ISSUE_PORTS-1:0][3:0]               fu_op;
  logic [ISSUE_PORTS-1:0][REG_SIZE-1:0]      fu_rs1;
  logic [ISSUE_PORTS-1:0][REG_SIZE-1:0]      fu_rs2;
  logic [ISSUE_PORTS-1:0][NUM_TAGS_LOG2-1:0] fu_tags;
  logic [ISSUE_PORTS-1:0][ROB_SIZE_LOG2-1:0] fu_rob_index;
  logic [ISSUE_PORTS-1:0]                    fu_valid;
  logic [ISSUE_PORTS-1:0]                    fu_loadstore;

  // result broadcast
  logic [ISSUE_PORTS-1:0][NUM_TAGS_LOG2-1:0] cdb_tags;
  logic [ISSUE_PORTS-1:0][REG_SIZE-1:0]      cdb_data;
  logic [ISSUE_PORTS-1:0][ROB_SIZE_LOG2-1:0] cdb_rob_index;
  logic [ISSUE_PORTS-1:0]                    cdb_valid;

  // address FIFO
  logic [REG_SIZE-1:0]      agu_addr;
  logic [ROB_SIZE_LOG2-1:0] agu_rob_index;
  logic                     agu_valid;
  logic                     agu_ready;
  logic                     ex_stall;
  logic                     agu_overflow;

  modport slave (
    input  fu_op, fu_rs1, fu_rs2, fu_tags, fu_rob_index, fu_valid, fu_loadstore,
    input  agu_ready,
    output cdb_tags, cdb_data, cdb_rob_index, cdb_valid,
    output agu_addr, agu_rob_index, agu_valid, ex_stall, agu_overflow
  );

  modport master (
    output fu_op, fu_rs1, fu_rs2, fu_tags, fu_rob_index, fu_valid, fu_loadstore,
    output agu_ready,
    input  cdb_tags, cdb_data, cdb_rob_index, cdb_valid,
    input  agu_addr, agu_rob_index, agu_valid, ex_stall, agu_overflow
  );
endinterface

// File: rtl/execute_writeback.sv
// Execute/writeback stage: one ALU per issue lane with a registered result
// broadcast on the matching CDB port, plus an address FIFO that collects
// load/store effective addresses (lower lanes enqueue first).
module execute_writeback #(
  parameter int ISSUE_PORTS = 3,
  parameter int REG_SIZE    = 32,
  parameter int NUM_TAGS    = 64,
  parameter int ROB_SIZE    = 64,
  parameter int AGU_DEPTH   = 4
) (
  input logic                clk,
  input logic                rst,
  execute_writeback_if.slave bus
);
  localparam int TAG_W = $clog2(NUM_TAGS);
  localparam int ROB_W = $clog2(ROB_SIZE);
  localparam int PTR_W = $clog2(AGU_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // ALU: shifts use the low five bits of rs2; unused opcodes yield zero.
  function automatic logic [REG_SIZE-1:0] alu_f(
    input logic [3:0]          op,
    input logic [REG_SIZE-1:0] a,
    input logic [REG_SIZE-1:0] b
  );
    logic [4:0]          sh;
    logic [REG_SIZE-1:0] res;
    sh = b[4:0];
    case (op)
      4'd0:    res = a + b;
      4'd1:    res = a - b;
      4'd2:    res = a ^ b;
      4'd3:    res = a | b;
      4'd4:    res = a & b;
      4'd5:    res = a << sh;
      4'd6:    res = a >> sh;
      4'd7:    res = $signed(a) >>> sh;
      4'd8:    res = {{(REG_SIZE-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd9:    res = {{(REG_SIZE-1){1'b0}}, (a < b)};
      default: res = {REG_SIZE{1'b0}};
    endcase
    return res;
  endfunction

  // result broadcast registers
  logic [ISSUE_PORTS-1:0][TAG_W-1:0]    cdb_tags_r;
  logic [ISSUE_PORTS-1:0][REG_SIZE-1:0] cdb_data_r;
  logic [ISSUE_PORTS-1:0][ROB_W-1:0]    cdb_rob_r;
  logic [ISSUE_PORTS-1:0]               cdb_valid_r;

  // address FIFO state
  logic [REG_SIZE-1:0] addr_mem_r [AGU_DEPTH];
  logic [ROB_W-1:0]    rob_mem_r  [AGU_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic                overflow_r;

  // FIFO control
  logic                              agu_valid_s;
  logic                              deq_s;
  logic [CNT_W-1:0]                  free_s;
  logic [CNT_W-1:0]                  acc_s;
  logic                              dropped_s;
  logic [ISSUE_PORTS-1:0]            we_s;
  logic [ISSUE_PORTS-1:0][PTR_W-1:0] slot_s;

  assign agu_valid_s = (count_r != {CNT_W{1'b0}});

  // Enqueue allocation: the same-cycle dequeue frees its slot first, then
  // load/store lanes claim free slots in lane order; the rest are dropped.
  always_comb begin
    deq_s     = agu_valid_s & bus.agu_ready;
    free_s    = CNT_W'(AGU_DEPTH) - count_r + {{PTR_W{1'b0}}, deq_s};
    acc_s     = {CNT_W{1'b0}};
    dropped_s = 1'b0;
    we_s      = {ISSUE_PORTS{1'b0}};
    slot_s    = {(ISSUE_PORTS*PTR_W){1'b0}};
    for (int l = 0; l < ISSUE_PORTS; l++) begin
      if (bus.fu_valid[l] && bus.fu_loadstore[l]) begin
        if (acc_s < free_s) begin
          we_s[l]   = 1'b1;
          slot_s[l] = wr_ptr_r + acc_s[PTR_W-1:0];
          acc_s     = acc_s + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          dropped_s = 1'b1;
        end
      end else begin
        we_s[l] = 1'b0;
      end
    end
  end

  // CDB: capture ALU results for valid non-memory lanes, otherwise hold payload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_tags_r  <= {(ISSUE_PORTS*TAG_W){1'b0}};
      cdb_data_r  <= {(ISSUE_PORTS*REG_SIZE){1'b0}};
      cdb_rob_r   <= {(ISSUE_PORTS*ROB_W){1'b0}};
      cdb_valid_r <= {ISSUE_PORTS{1'b0}};
    end else begin
      for (int l = 0; l < ISSUE_PORTS; l++) begin
        if (bus.fu_valid[l] && !bus.fu_loadstore[l]) begin
          cdb_valid_r[l] <= 1'b1;
          cdb_data_r[l]  <= alu_f(bus.fu_op[l], bus.fu_rs1[l], bus.fu_rs2[l]);
          cdb_tags_r[l]  <= bus.fu_tags[l];
          cdb_rob_r[l]   <= bus.fu_rob_index[l];
        end else begin
          cdb_valid_r[l] <= 1'b0;
        end
      end
    end
  end

  // FIFO storage: write accepted effective addresses into their allocated slots.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < AGU_DEPTH; i++) begin
        addr_mem_r[i] <= {REG_SIZE{1'b0}};
        rob_mem_r[i]  <= {ROB_W{1'b0}};
      end
    end else begin
      for (int l = 0; l < ISSUE_PORTS; l++) begin
        if (we_s[l]) begin
          addr_mem_r[slot_s[l]] <= bus.fu_rs1[l] + bus.fu_rs2[l];
          rob_mem_r[slot_s[l]]  <= bus.fu_rob_index[l];
        end
      end
    end
  end

  // FIFO pointers, occupancy and the one-cycle drop indication.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      wr_ptr_r   <= wr_ptr_r + acc_s[PTR_W-1:0];
      rd_ptr_r   <= rd_ptr_r + {{(PTR_W-1){1'b0}}, deq_s};
      count_r    <= count_r - {{PTR_W{1'b0}}, deq_s} + acc_s;
      overflow_r <= dropped_s;
    end
  end

  assign bus.cdb_tags      = cdb_tags_r;
  assign bus.cdb_data      = cdb_data_r;
  assign bus.cdb_rob_index = cdb_rob_r;
  assign bus.cdb_valid     = cdb_valid_r;
  assign bus.agu_addr      = addr_mem_r[rd_ptr_r];
  assign bus.agu_rob_index = rob_mem_r[rd_ptr_r];
  assign bus.agu_valid     = agu_valid_s;
  assign bus.agu_overflow  = overflow_r;
  // Stall while the FIFO could not absorb a full issue group.
  assign bus.ex_stall      = (AGU_DEPTH - int'(count_r)) < ISSUE_PORTS;
endmodule

// File: tb/tb_execute_writeback.sv
// Directed testbench for execute_writeback: inputs change and outputs are
// sampled on the falling clock edge.
module tb_execute_writeback;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  execute_writeback_if bus ();
  execute_writeback dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // ALU vectors: three cycles of three lanes
  localparam logic [3:0]  OPS [9] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd9, 4'd12, 4'd8};
  localparam logic [31:0] AV  [9] = '{32'd5, 32'hF0F0F0F0, 32'h00000F00, 32'hFF00FF00, 32'd1,
                                      32'h80000000, 32'd1, 32'd123, 32'd5};
  localparam logic [31:0] BV  [9] = '{32'd7, 32'hFF00FF00, 32'h000000F0, 32'h0F0F0F0F, 32'h3F,
                                      32'd4, 32'hFFFFFFFF, 32'd456, 32'hFFFFFFFD};
  localparam logic [31:0] EV  [9] = '{32'hFFFFFFFE, 32'h0FF00FF0, 32'h00000FF0, 32'h0F000F00,
                                      32'h80000000, 32'h08000000, 32'd1, 32'd0, 32'd0};
  localparam logic [5:0]  TV  [9] = '{6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17, 6'd18, 6'd0};

  task automatic clear_inputs();
    bus.fu_valid     = '0;
    bus.fu_loadstore = '0;
    bus.fu_op        = '0;
    bus.fu_rs1       = '0;
    bus.fu_rs2       = '0;
    bus.fu_tags      = '0;
    bus.fu_rob_index = '0;
  endtask

  task automatic set_lane(input int l, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [5:0] tag,
                          input logic [5:0] rob, input logic ls);
    bus.fu_op[l]        = op;
    bus.fu_rs1[l]       = a;
    bus.fu_rs2[l]       = b;
    bus.fu_tags[l]      = tag;
    bus.fu_rob_index[l] = rob;
    bus.fu_loadstore[l] = ls;
    bus.fu_valid[l]     = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.agu_ready = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    checks++; if (bus.cdb_valid !== 3'b000) begin errors++; $display("FAIL reset_cdb_valid got=%b exp=000", bus.cdb_valid); end
    checks++; if (bus.cdb_data !== 96'd0) begin errors++; $display("FAIL reset_cdb_data got=%h exp=0", bus.cdb_data); end
    checks++; if (bus.agu_valid !== 1'b0) begin errors++; $display("FAIL reset_agu_valid got=%b exp=0", bus.agu_valid); end
    checks++; if (bus.agu_addr !== 32'd0) begin errors++; $display("FAIL reset_agu_addr got=%h exp=0", bus.agu_addr); end
    checks++; if (bus.ex_stall !== 1'b0) begin errors++; $display("FAIL reset_ex_stall got=%b exp=0", bus.ex_stall); end
    checks++; if (bus.agu_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", bus.agu_overflow); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.ex_stall !== 1'b0) begin errors++; $display("FAIL post_reset_ex_stall got=%b exp=0", bus.ex_stall); end
  endtask

  task automatic test_add_wrap();
    set_lane(0, 4'd0, 32'hFFFFFFFF, 32'd1, 6'd5, 6'd3, 1'b0);
    @(negedge clk);
    clear_inputs();
    checks++; if (bus.cdb_valid !== 3'b001) begin errors++; $display("FAIL add_valid got=%b exp=001", bus.cdb_valid); end
    checks++; if (bus.cdb_data[0] !== 32'd0) begin errors++; $display("FAIL add_data got=%h exp=0", bus.cdb_data[0]); end
    checks++; if (bus.cdb_tags[0] !== 6'd5) begin errors++; $display("FAIL add_tag got=%0d exp=5", bus.cdb_tags[0]); end
    checks++; if (bus.cdb_rob_index[0] !== 6'd3) begin errors++; $display("FAIL add_rob got=%0d exp=3", bus.cdb_rob_index[0]); end
    @(negedge clk);
    checks++; if (bus.cdb_valid !== 3'b000) begin errors++; $display("FAIL add_valid_drop got=%b exp=000", bus.cdb_valid); end
    checks++; if (bus.cdb_tags[0] !== 6'd5) begin errors++; $display("FAIL add_tag_hold got=%0d exp=5", bus.cdb_tags[0]); end
  endtask

  task automatic test_alu_ops();
    for (int c = 0; c < 3; c++) begin
      for (int l = 0; l < 3; l++)
        set_lane(l, OPS[c*3+l], AV[c*3+l], BV[c*3+l], TV[c*3+l], 6'(c*3+l), 1'b0);
      @(negedge clk);
      clear_inputs();
      checks++; if (bus.cdb_valid !== 3'b111) begin errors++; $display("FAIL alu_valid_c%0d got=%b exp=111", c, bus.cdb_valid); end
      for (int l = 0; l < 3; l++) begin
        checks++;
        if (bus.cdb_data[l] !== EV[c*3+l]) begin
          errors++; $display("FAIL alu_op%0d_lane%0d got=%h exp=%h", OPS[c*3+l], l, bus.cdb_data[l], EV[c*3+l]);
        end
        checks++;
        if (bus.cdb_tags[l] !== TV[c*3+l]) begin
          errors++; $display("FAIL alu_tag_lane%0d got=%0d exp=%0d", l, bus.cdb_tags[l], TV[c*3+l]);
        end
      end
    end
  endtask

  task automatic test_sra_slt();
    set_lane(1, 4'd7, 32'h80000000, 32'h24, 6'd1, 6'd1, 1'b0);
    set_lane(2, 4'd8, 32'hFFFFFFFF, 32'd0, 6'd2, 6'd2, 1'b0);
    @(negedge clk);
    clear_inputs();
    checks++; if (bus.cdb_valid !== 3'b110) begin errors++; $display("FAIL sra_slt_valid got=%b exp=110", bus.cdb_valid); end
    checks++; if (bus.cdb_data[1] !== 32'hF8000000) begin errors++; $display("FAIL sra got=%h exp=f8000000", bus.cdb_data[1]); end
    checks++; if (bus.cdb_data[2] !== 32'd1) begin errors++; $display("FAIL slt got=%h exp=1", bus.cdb_data[2]); end
    @(negedge clk);
    checks++; if (bus.cdb_data[1] !== 32'hF8000000) begin errors++; $display("FAIL sra_hold got=%h exp=f8000000", bus.cdb_data[1]); end
  endtask

  task automatic test_fifo_fill_drain();
    bus.agu_ready = 1'b0;
    for (int l = 0; l < 3; l++) set_lane(l, 4'd0, 32'h100, 32'(4*l), 6'd0, 6'(l+1), 1'b1);
    @(negedge clk);
    clear_inputs();
    checks++; if (bus.cdb_valid !== 3'b000) begin errors++; $display("FAIL ls_no_cdb got=%b exp=000", bus.cdb_valid); end
    checks++; if (bus.cdb_data[1] !== 32'hF8000000) begin errors++; $display("FAIL ls_cdb_hold got=%h exp=f8000000", bus.cdb_data[1]); end
    checks++; if (bus.agu_valid !== 1'b1) begin errors++; $display("FAIL fill_valid got=%b exp=1", bus.agu_valid); end
    checks++; if (bus.ex_stall !== 1'b1) begin errors++; $display("FAIL fill_stall got=%b exp=1", bus.ex_stall); end
    @(negedge clk);
    checks++; if (bus.agu_addr !== 32'h100) begin errors++; $display("FAIL fill_head_stable got=%h exp=100", bus.agu_addr); end
    bus.agu_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.agu_addr !== 32'(32'h100 + 4*i) || bus.agu_rob_index !== 6'(i+1)) begin
        errors++; $display("FAIL drain%0d got=%h/%0d exp=%h/%0d", i, bus.agu_addr, bus.agu_rob_index, 32'h100 + 4*i, i+1);
      end
      @(negedge clk);
    end
    bus.agu_ready = 1'b0;
    checks++; if (bus.agu_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", bus.agu_valid); end
    checks++; if (bus.ex_stall !== 1'b0) begin errors++; $display("FAIL drain_stall got=%b exp=0", bus.ex_stall); end
  endtask

  task automatic test_back_to_back_overflow();
    logic [31:0] exp_a [4];
    logic [5:0]  exp_r [4];
    exp_a = '{32'h204, 32'h208, 32'h300, 32'h304};
    exp_r = '{6'd5, 6'd6, 6'd7, 6'd8};
    bus.agu_ready = 1'b0;
    for (int l = 0; l < 3; l++) set_lane(l, 4'd0, 32'h200, 32'(4*l), 6'd0, 6'(l+4), 1'b1);
    @(negedge clk);
    clear_inputs();
    set_lane(0, 4'd0, 32'h300, 32'd0, 6'd0, 6'd7, 1'b1);
    set_lane(1, 4'd0, 32'h300, 32'd4, 6'd0, 6'd8, 1'b1);
    bus.agu_ready = 1'b1;
    @(negedge clk);
    clear_inputs();
    bus.agu_ready = 1'b0;
    checks++; if (bus.agu_overflow !== 1'b0) begin errors++; $display("FAIL concurrent_overflow got=%b exp=0", bus.agu_overflow); end
    checks++; if (bus.agu_addr !== 32'h204) begin errors++; $display("FAIL concurrent_head got=%h exp=204", bus.agu_addr); end
    set_lane(0, 4'd0, 32'h400, 32'd0, 6'd0, 6'd9, 1'b1);
    @(negedge clk);
    clear_inputs();
    checks++; if (bus.agu_overflow !== 1'b1) begin errors++; $display("FAIL full_overflow got=%b exp=1", bus.agu_overflow); end
    checks++; if (bus.agu_addr !== 32'h204) begin errors++; $display("FAIL full_head got=%h exp=204", bus.agu_addr); end
    @(negedge clk);
    checks++; if (bus.agu_overflow !== 1'b0) begin errors++; $display("FAIL overflow_pulse got=%b exp=0", bus.agu_overflow); end
    bus.agu_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.agu_addr !== exp_a[i] || bus.agu_rob_index !== exp_r[i]) begin
        errors++; $display("FAIL full_drain%0d got=%h/%0d exp=%h/%0d", i, bus.agu_addr, bus.agu_rob_index, exp_a[i], exp_r[i]);
      end
      @(negedge clk);
    end
    bus.agu_ready = 1'b0;
    checks++; if (bus.agu_valid !== 1'b0) begin errors++; $display("FAIL full_drain_empty got=%b exp=0", bus.agu_valid); end
  endtask

  task automatic test_partial_drop();
    bus.agu_ready = 1'b0;
    for (int l = 0; l < 3; l++) set_lane(l, 4'd0, 32'h500, 32'(4*l), 6'd0, 6'(l+10), 1'b1);
    @(negedge clk);
    for (int l = 0; l < 3; l++) set_lane(l, 4'd0, 32'h600, 32'(4*l), 6'd0, 6'(l+13), 1'b1);
    @(negedge clk);
    clear_inputs();
    checks++; if (bus.agu_overflow !== 1'b1) begin errors++; $display("FAIL partial_overflow got=%b exp=1", bus.agu_overflow); end
    bus.agu_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.agu_addr !== ((i < 3) ? 32'(32'h500 + 4*i) : 32'h600)) begin
        errors++; $display("FAIL partial_drain%0d got=%h", i, bus.agu_addr);
      end
      @(negedge clk);
    end
    bus.agu_ready = 1'b0;
    checks++; if (bus.agu_valid !== 1'b0) begin errors++; $display("FAIL partial_empty got=%b exp=0", bus.agu_valid); end
  endtask

  task automatic test_reset_mid();
    bus.agu_ready = 1'b0;
    set_lane(0, 4'd0, 32'h700, 32'd0, 6'd0, 6'd1, 1'b1);
    set_lane(1, 4'd0, 32'h700, 32'd4, 6'd0, 6'd2, 1'b1);
    set_lane(2, 4'd0, 32'd10, 32'd20, 6'd3, 6'd4, 1'b0);
    @(negedge clk);
    clear_inputs();
    checks++; if (bus.cdb_valid !== 3'b100 || bus.agu_valid !== 1'b1) begin errors++; $display("FAIL pre_reset got=%b/%b exp=100/1", bus.cdb_valid, bus.agu_valid); end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.cdb_valid !== 3'b000) begin errors++; $display("FAIL async_cdb_valid got=%b exp=000", bus.cdb_valid); end
    checks++; if (bus.agu_valid !== 1'b0) begin errors++; $display("FAIL async_agu_valid got=%b exp=0", bus.agu_valid); end
    checks++; if (bus.cdb_data !== 96'd0 || bus.cdb_tags !== 18'd0) begin errors++; $display("FAIL async_cdb_payload got=%h exp=0", bus.cdb_data); end
    checks++; if (bus.agu_addr !== 32'd0 || bus.ex_stall !== 1'b0) begin errors++; $display("FAIL async_agu got=%h/%b exp=0/0", bus.agu_addr, bus.ex_stall); end
    @(negedge clk);
    rst = 1'b1;
    set_lane(0, 4'd0, 32'd3, 32'd4, 6'd7, 6'd9, 1'b0);
    @(negedge clk);
    clear_inputs();
    checks++; if (bus.cdb_valid !== 3'b001 || bus.cdb_data[0] !== 32'd7) begin errors++; $display("FAIL post_reset_add got=%b/%h exp=001/7", bus.cdb_valid, bus.cdb_data[0]); end
    checks++; if (bus.cdb_tags[0] !== 6'd7 || bus.cdb_rob_index[0] !== 6'd9) begin errors++; $display("FAIL post_reset_tag got=%0d/%0d exp=7/9", bus.cdb_tags[0], bus.cdb_rob_index[0]); end
    checks++; if (bus.agu_valid !== 1'b0) begin errors++; $display("FAIL post_reset_fifo got=%b exp=0", bus.agu_valid); end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_alu_ops();
    test_sra_slt();
    test_fifo_fill_drain();
    test_back_to_back_overflow();
    test_partial_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout reached before completion");
    $fatal(1);
  end
endmodule
